// File: rtl/mux_pkg.sv
// Shared definitions for the arbitrating multiplexer: selection mode encoding.
package mux_pkg;

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'b00,
        MODE_FIXED  = 2'b01,
        MODE_RR     = 2'b10,
        MODE_RSVD   = 2'b11
    } mux_mode_t;

endpackage : mux_pkg

// File: rtl/rr_arbiter.sv
// Priority / round-robin arbiter: picks the first requesting channel searching
// upward from a start index (0 for fixed priority, rr_ptr for round-robin),
// wrapping at N_CH-1. Produces a one-hot grant and its encoded index.
module rr_arbiter #(
    parameter int N_CH  = 4,
    parameter int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] rr_ptr,
    input  logic             use_rr,
    output logic [N_CH-1:0]  grant,
    output logic [SEL_W-1:0] grant_idx
);

    int   start;
    logic found;

    // Two passes implement the wrap: first channels at/above start, then below it.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        start     = use_rr ? int'(rr_ptr) : 0;
        if (start >= N_CH) begin
            start = 0;
        end
        for (int i = 0; i < N_CH; i++) begin
            if (!found && req[i] && (i >= start)) begin
                grant[i]  = 1'b1;
                grant_idx = SEL_W'(i);
                found     = 1'b1;
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            if (!found && req[i] && (i < start)) begin
                grant[i]  = 1'b1;
                grant_idx = SEL_W'(i);
                found     = 1'b1;
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/arb_mux_n.sv
// N-channel arbitrating multiplexer with a one-deep registered output.
// Grant is combinational (manual / fixed / round-robin); the output register
// loads whenever it is empty or being drained in the same cycle.
module arb_mux_n
    import mux_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int DATA_W = 8,
    parameter int SEL_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             mode,
    input  logic [SEL_W-1:0]       sel,
    input  logic [N_CH-1:0]        in_valid,
    output logic [N_CH-1:0]        in_ready,
    input  logic [N_CH*DATA_W-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [SEL_W-1:0]       out_ch
);

    mux_mode_t          mode_e;
    logic [N_CH-1:0]    man_grant;
    logic [N_CH-1:0]    arb_grant;
    logic [SEL_W-1:0]   arb_idx;
    logic [N_CH-1:0]    grant;
    logic [SEL_W-1:0]   grant_idx;
    logic [DATA_W-1:0]  grant_data;
    logic               load_en;
    logic               xfer;

    logic               out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  out_data_q,  out_data_d;
    logic [SEL_W-1:0]   out_ch_q,    out_ch_d;
    logic [SEL_W-1:0]   rr_ptr_q,    rr_ptr_d;

    assign mode_e = mux_mode_t'(mode);

    rr_arbiter #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_arb (
        .req       (in_valid),
        .rr_ptr    (rr_ptr_q),
        .use_rr    (mode_e == MODE_RR),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    // Manual select: an out-of-range sel matches no channel, so it never grants.
    always_comb begin
        man_grant = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (sel == SEL_W'(i)) begin
                man_grant[i] = in_valid[i];
            end
        end
    end

    // Mode selection of the grant source; reserved mode grants nothing.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        case (mode_e)
            MODE_MANUAL: begin
                grant     = man_grant;
                grant_idx = sel;
            end
            MODE_FIXED, MODE_RR: begin
                grant     = arb_grant;
                grant_idx = arb_idx;
            end
            default: begin
                grant     = '0;
                grant_idx = '0;
            end
        endcase
    end

    // One-hot data select from the granted channel.
    always_comb begin
        grant_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) begin
                grant_data = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // rst_n gates the handshake so no channel sees ready while held in reset.
    assign load_en  = rst_n && (!out_valid_q || out_ready);
    assign in_ready = load_en ? grant : '0;
    assign xfer     = |in_ready;

    // Output register and round-robin pointer next-state.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_data;
            out_ch_d    = grant_idx;
            rr_ptr_d    = (grant_idx == SEL_W'(N_CH - 1)) ? '0 : grant_idx + SEL_W'(1);
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule : arb_mux_n
